// File: rtl/chassis_uart_pkg.sv
// Shared constants and parser state encoding for the chassis UART command path.
package chassis_uart_pkg;

    localparam logic [7:0] HDR1 = 8'hAA;
    localparam logic [7:0] HDR2 = 8'h55;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR2,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } parser_state_t;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: 16-bit down-counter reloaded on every byte, decremented while enabled.
// expire_o pulses combinationally in the last counted cycle; a reload in that cycle suppresses it.
module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT_CYC);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = LOAD_VAL;
        end else if (enable_i && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i & ~reload_i & (cnt_q == 16'd1);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles AA 55 CMD LEN payload CSUM frames from UART bytes; strobes frame_valid/frame_err
// one cycle after the byte event that completes or breaks a frame. Held outputs change only on frame_valid.
module uart_cmd_parser
    import chassis_uart_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   frame_valid,
    output logic [7:0]             cmd,
    output logic [3:0]             len,
    output logic [8*MAX_LEN-1:0]   payload,
    output logic                   frame_err,
    output logic [1:0]             err_code
);

    parser_state_t state_q, state_d;

    logic                 rx_rdy_q;
    logic                 byte_evt;
    logic                 tmo_expire;
    logic                 len_bad;
    logic                 pay_last;
    logic                 csum_ok;

    logic [7:0]           sh_cmd_q;
    logic [3:0]           sh_len_q;
    logic [8*MAX_LEN-1:0] sh_pay_q;
    logic [7:0]           sum_q;
    logic [3:0]           idx_q;

    logic                 valid_d, err_d;
    logic [1:0]           code_d;
    logic                 frame_valid_q, frame_err_q;
    logic [1:0]           err_code_q;
    logic [7:0]           cmd_q;
    logic [3:0]           len_q;
    logic [8*MAX_LEN-1:0] payload_q;

    // A receiver strobe held for several cycles still counts as a single byte.
    assign byte_evt = rx_rdy & ~rx_rdy_q;
    assign len_bad  = rx_data > 8'(MAX_LEN);
    assign pay_last = (idx_q + 4'd1) == sh_len_q;
    assign csum_ok  = rx_data == sum_q;

    uart_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .reload_i (byte_evt),
        .enable_i (state_q != ST_IDLE),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_evt) begin
            case (state_q)
                ST_IDLE:    if (rx_data == HDR1) state_d = ST_HDR2;
                ST_HDR2: begin
                    if (rx_data == HDR2)      state_d = ST_CMD;
                    else if (rx_data == HDR1) state_d = ST_HDR2;
                    else                      state_d = ST_IDLE;
                end
                ST_CMD:     state_d = ST_LEN;
                ST_LEN: begin
                    if (len_bad)                state_d = ST_IDLE;
                    else if (rx_data == 8'h00)  state_d = ST_CSUM;
                    else                        state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: if (pay_last) state_d = ST_CSUM;
                ST_CSUM:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else if (tmo_expire) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code_q;
        if (byte_evt && (state_q == ST_LEN) && len_bad) begin
            err_d  = 1'b1;
            code_d = ERR_LEN;
        end else if (byte_evt && (state_q == ST_CSUM)) begin
            valid_d = csum_ok;
            err_d   = ~csum_ok;
            if (!csum_ok) code_d = ERR_CSUM;
        end else if (!byte_evt && tmo_expire) begin
            err_d  = 1'b1;
            code_d = ERR_TMO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_q <= 1'b0;
            sh_cmd_q <= 8'd0;
            sh_len_q <= 4'd0;
            sh_pay_q <= '0;
            sum_q    <= 8'd0;
            idx_q    <= 4'd0;
        end else begin
            rx_rdy_q <= rx_rdy;
            if (byte_evt) begin
                case (state_q)
                    ST_CMD: begin
                        sh_cmd_q <= rx_data;
                        sum_q    <= rx_data;
                        sh_pay_q <= '0;
                    end
                    ST_LEN: begin
                        sh_len_q <= rx_data[3:0];
                        sum_q    <= sum_q + rx_data;
                        idx_q    <= 4'd0;
                    end
                    ST_PAYLOAD: begin
                        for (int i = 0; i < int'(MAX_LEN); i++) begin
                            if (idx_q == 4'(i)) sh_pay_q[8*i +: 8] <= rx_data;
                        end
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            cmd_q         <= 8'd0;
            len_q         <= 4'd0;
            payload_q     <= '0;
        end else begin
            frame_valid_q <= valid_d;
            frame_err_q   <= err_d;
            err_code_q    <= code_d;
            if (valid_d) begin
                cmd_q     <= sh_cmd_q;
                len_q     <= sh_len_q;
                payload_q <= sh_pay_q;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign cmd         = cmd_q;
    assign len         = len_q;
    assign payload     = payload_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus hand-timed latency, timeout and reset sequences.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    localparam int MAXL = 8;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        frame_valid;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] payload;
    logic        frame_err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int nv = 0, ne = 0, nboth = 0;

    uart_cmd_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .frame_valid (frame_valid),
        .cmd         (cmd),
        .len         (len),
        .payload     (payload),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nv++;
        if (frame_err) ne++;
        if (frame_valid && frame_err) nboth++;
    end

    typedef struct {
        logic [191:0] b;
        int           n;
        int           hold;
        int           ev;
        int           ee;
        logic [1:0]   code;
        logic [7:0]   c;
        logic [3:0]   l;
        logic [63:0]  p;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [191:0] b, input int n, input int hold, input int ev,
                           input int ee, input logic [1:0] code, input logic [7:0] c,
                           input logic [3:0] l, input logic [63:0] p);
        vec_t v;
        v.b = b; v.n = n; v.hold = hold; v.ev = ev; v.ee = ee;
        v.code = code; v.c = c; v.l = l; v.p = p;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1 rx_data = b;
        rx_rdy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int bv, be;
        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_rdy = 1'b0;

        add_vec(192'hAA55010210_2033, 7, 1, 1, 0, 2'b00, 8'h01, 4'd2, 64'h2010);
        add_vec(192'hAA55010210_2034, 7, 1, 0, 1, 2'b10, 8'h01, 4'd2, 64'h2010);
        add_vec(192'hAA550509,        4, 1, 0, 1, 2'b01, 8'h01, 4'd2, 64'h2010);
        add_vec(192'hAA550503010203_0E, 8, 1, 1, 0, 2'b01, 8'h05, 4'd3, 64'h030201);
        add_vec(192'h12AAAA55070007,  7, 2, 1, 0, 2'b01, 8'h07, 4'd0, 64'h0);
        add_vec(192'hAA55090801020304050607_0835, 13, 1, 1, 0, 2'b01, 8'h09, 4'd8,
                64'h0807060504030201);
        add_vec(192'hAA550009,        4, 1, 0, 1, 2'b01, 8'h09, 4'd8, 64'h0807060504030201);
        add_vec(192'hAA1355010001,    6, 1, 0, 0, 2'b01, 8'h09, 4'd8, 64'h0807060504030201);
        add_vec(192'hAA550201FF02AA55030003, 11, 1, 2, 0, 2'b01, 8'h03, 4'd0, 64'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_err",   64'(frame_err),   64'd0);
        chk("rst_code",  64'(err_code),    64'd0);
        chk("rst_cmd",   64'(cmd),         64'd0);
        chk("rst_len",   64'(len),         64'd0);
        chk("rst_pay",   payload,          64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[k]) begin
            bv = nv; be = ne;
            for (int j = 0; j < vecs[k].n; j++)
                send_byte(vecs[k].b[(vecs[k].n - 1 - j) * 8 +: 8], vecs[k].hold);
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_nvalid", k), 64'(nv - bv), 64'(vecs[k].ev));
            chk($sformatf("v%0d_nerr", k),   64'(ne - be), 64'(vecs[k].ee));
            chk($sformatf("v%0d_code", k),   64'(err_code), 64'(vecs[k].code));
            chk($sformatf("v%0d_cmd", k),    64'(cmd), 64'(vecs[k].c));
            chk($sformatf("v%0d_len", k),    64'(len), 64'(vecs[k].l));
            chk($sformatf("v%0d_pay", k),    payload, vecs[k].p);
        end

        // strobe lands exactly one cycle after the CSUM byte event
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h04, 1); send_byte(8'h00, 1);
        @(posedge clk);
        #1 rx_data = 8'h04; rx_rdy = 1'b1;
        @(negedge clk);
        chk("lat_T", 64'(frame_valid), 64'd0);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        @(negedge clk);
        chk("lat_T1",     64'(frame_valid), 64'd1);
        chk("lat_T1_cmd", 64'(cmd), 64'h04);
        @(negedge clk);
        chk("lat_T2", 64'(frame_valid), 64'd0);

        // timeout after CMD byte
        be = ne;
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h01, 1);
        repeat (TMO) @(negedge clk);
        chk("tmo_early", 64'(frame_err), 64'd0);
        @(negedge clk);
        chk("tmo_pulse", 64'(frame_err), 64'd1);
        repeat (5) @(negedge clk);
        chk("tmo_count", 64'(ne - be), 64'd1);
        chk("tmo_code",  64'(err_code), 64'b11);
        chk("tmo_cmd",   64'(cmd), 64'h04);

        // byte on the expiry cycle wins
        be = ne; bv = nv;
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h01, 1);
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h00, 1);
        repeat (3) @(negedge clk);
        chk("exp_byte_noerr", 64'(ne - be), 64'd0);
        send_byte(8'h01, 1);
        repeat (3) @(negedge clk);
        chk("exp_byte_valid", 64'(nv - bv), 64'd1);
        chk("exp_byte_cmd",   64'(cmd), 64'h01);
        chk("exp_byte_err",   64'(ne - be), 64'd0);

        // reset mid-frame
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h03, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd",  64'(cmd), 64'd0);
        chk("mid_rst_code", 64'(err_code), 64'd0);
        chk("mid_rst_pay",  payload, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        be = ne; bv = nv;
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        repeat (5) @(negedge clk);
        chk("post_rst_valid", 64'(nv - bv), 64'd0);
        chk("post_rst_err",   64'(ne - be), 64'd0);
        chk("post_rst_len",   64'(len), 64'd0);

        chk("never_both", 64'(nboth), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level frame parser sitting directly downstream of the chassis UART receiver. Consumes received bytes and their ready strobe, and assembles them into command frames (header, command, length, payload, checksum). Presents each validated frame to the chassis control logic as a one-cycle strobe with held command/payload registers. Malformed or stalled frames are reported through an error strobe and code.

## Interface
- MAX_LEN, 8: maximum payload bytes per frame (1..15).
- TIMEOUT_CYC, 50000: inter-byte timeout in clk cycles (2 ms at 25 MHz); counter width 16 bits.
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received byte; valid whenever rx_rdy is high.
- rx_rdy  in  1  byte-ready strobe from the receiver; may stay high 1–2 cycles per byte.
- frame_valid  out  1  one-cycle pulse when a frame passes checksum.
- cmd  out  8  command byte of last valid frame.
- len  out  4  payload length of last valid frame.
- payload  out  8*MAX_LEN  payload of last valid frame; byte i at [8i+7:8i]; bytes ≥ len are zero.
- frame_err  out  1  one-cycle pulse on frame error.
- err_code  out  2  cause of last error: 01 length, 10 checksum, 11 timeout; held until next error.

## Operation
- Byte event: rx_rdy & ~rx_rdy_d (rx_rdy_d registered copy). Multi-cycle rx_rdy counts as one byte.
- Frame: 0xAA, 0x55, CMD, LEN, LEN payload bytes, CSUM. CSUM = (CMD + LEN + Σpayload) mod 256.
- States and transitions on byte event:
  - IDLE: 0xAA → HDR2; else stay.
  - HDR2: 0x55 → CMD; 0xAA → stay HDR2; else → IDLE. No error reported.
  - CMD: latch cmd into shadow, sum ← byte, clear shadow payload → LEN.
  - LEN: byte > MAX_LEN → frame_err, err_code=01, IDLE. byte == 0 → CSUM; else → PAYLOAD, idx ← 0. sum += byte.
  - PAYLOAD: shadow[idx] ← byte, sum += byte, idx++; idx reaching LEN → CSUM.
  - CSUM: byte == sum → copy shadow to cmd/len/payload, frame_valid; else frame_err, err_code=10. Either way → IDLE.
- Timeout: counter reloads on every byte event; counts in every state except IDLE. Reaching TIMEOUT_CYC → frame_err, err_code=11, IDLE. Byte event on the expiry cycle wins: byte is processed, no timeout.
- Output registers change only on frame_valid. Failed frames never disturb held outputs.
- Back-to-back frames with no idle gap are accepted.

## Timing
- Reset: frame_valid=0, frame_err=0, err_code=00, cmd=0, len=0, payload=0, state IDLE, counters 0.
- Byte event detected in cycle T (rx_rdy first sampled high at T); state update at end of T; frame_valid/frame_err high during T+1 exactly one cycle.
- Outputs cmd/len/payload become valid in the same cycle as frame_valid.
- Reset mid-frame discards all partial state; no strobes follow release.
- frame_valid and frame_err never assert together.

## Structure
- Shared package chassis_uart_pkg: HDR1=0xAA, HDR2=0x55, err code constants (ERR_LEN, ERR_CSUM, ERR_TMO), parser state encoding.
- One sub-module: uart_byte_timeout (16-bit reloadable down-counter, inputs reload/enable, output expire pulse).

## Test plan
- AA 55 01 02 10 20 33 → frame_valid once; cmd=0x01, len=2, payload[15:0]=0x2010, upper bytes 0.
- Same frame with CSUM 0x34 → frame_err, err_code=10; cmd/len/payload unchanged from prior frame.
- AA 55 05 09 → frame_err, err_code=01 immediately after LEN byte; next valid frame accepted.
- AA 55 01, then no bytes for TIMEOUT_CYC cycles → frame_err, err_code=11 once; a byte arriving exactly on expiry cycle suppresses it.
- Garbage 12 AA AA 55 07 00 07 with rx_rdy held 2 cycles per byte → single frame_valid, cmd=0x07, len=0.
- Assert rst_n low after AA 55 03 → all outputs reset values; subsequent 02 00 bytes produce no strobe.
